// File: rtl/sipo_frame_pkg.sv
// -----------------------------------------------------------------------------
// sipo_frame_pkg
// Shared types and helpers for the multi-lane SIPO frame collector.
//   sipo_state_t : collector state (FILL = collecting beats, FULL = frame held)
//   eff_len()    : maps a requested frame length onto the usable range 1..depth
// -----------------------------------------------------------------------------
package sipo_frame_pkg;

    typedef enum logic {
        FILL = 1'b0,
        FULL = 1'b1
    } sipo_state_t;

    // A length of 0, or one longer than the register, selects the full depth.
    function automatic int unsigned eff_len(input int unsigned len_req,
                                            input int unsigned depth);
        int unsigned v;
        if ((len_req == 32'd0) || (len_req > depth)) begin
            v = depth;
        end else begin
            v = len_req;
        end
        return v;
    endfunction

endpackage

// File: rtl/sipo_lane.sv
// -----------------------------------------------------------------------------
// sipo_lane
// One serial lane: a DEPTH-bit shift register plus a running ones-count.
// Ports:
//   clk, reset      : clock, asynchronous active-high reset
//   clear           : synchronous abort, zeroes register and count
//   shift           : accept one bit from 'in' this cycle
//   restart         : drop the current contents first (new frame / frame taken)
//   dir             : 1 = new bit enters MSB (right shift), 0 = enters LSB
//   in              : serial bit
//   data, ones      : register contents and ones-count
// -----------------------------------------------------------------------------
module sipo_lane
    import sipo_frame_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             shift,
    input  logic             restart,
    input  logic             dir,
    input  logic             in,
    output logic [DEPTH-1:0] data,
    output logic [CNT_W-1:0] ones
);

    logic [DEPTH-1:0] r_data;
    logic [CNT_W-1:0] r_ones;
    logic [DEPTH-1:0] w_first_msb;
    logic [DEPTH-1:0] w_first_lsb;
    logic [CNT_W-1:0] w_in_ext;

    // A restart-with-shift loads the bit as if shifted into an all-zero register.
    assign w_first_msb = {in, {(DEPTH-1){1'b0}}};
    assign w_first_lsb = {{(DEPTH-1){1'b0}}, in};
    assign w_in_ext    = {{(CNT_W-1){1'b0}}, in};

    // Shift register and ones-counter update.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_data <= {DEPTH{1'b0}};
            r_ones <= {CNT_W{1'b0}};
        end else if (clear) begin
            r_data <= {DEPTH{1'b0}};
            r_ones <= {CNT_W{1'b0}};
        end else if (restart) begin
            if (shift) begin
                r_data <= dir ? w_first_msb : w_first_lsb;
                r_ones <= w_in_ext;
            end else begin
                r_data <= {DEPTH{1'b0}};
                r_ones <= {CNT_W{1'b0}};
            end
        end else if (shift) begin
            r_data <= dir ? {in, r_data[DEPTH-1:1]} : {r_data[DEPTH-2:0], in};
            r_ones <= r_ones + w_in_ext;
        end else begin
            r_data <= r_data;
            r_ones <= r_ones;
        end
    end

    assign data = r_data;
    assign ones = r_ones;

endmodule

// File: rtl/sipo_frame_shift.sv
// -----------------------------------------------------------------------------
// sipo_frame_shift
// Multi-lane handshaked serial-in/parallel-out frame collector.
// Ports:
//   clk, reset            : clock, asynchronous active-high reset
//   clear                 : synchronous abort of partial or held frame
//   dir, len              : shift direction / frame length, latched at frame start
//   in_valid/in_ready     : beat handshake, in_data carries one bit per lane
//   out_valid/out_ready   : frame handshake
//   out_data              : lane i at [i*DEPTH +: DEPTH]
//   out_ones              : lane i ones-count at [i*CNT_W +: CNT_W]
// -----------------------------------------------------------------------------
module sipo_frame_shift
    import sipo_frame_pkg::*;
#(
    parameter  int LANES = 4,
    parameter  int DEPTH = 16,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   clear,
    input  logic                   dir,
    input  logic [CNT_W-1:0]       len,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [LANES-1:0]       in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [LANES*DEPTH-1:0] out_data,
    output logic [LANES*CNT_W-1:0] out_ones
);

    sipo_state_t      r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_dir;
    logic [CNT_W-1:0] r_len;

    logic             w_accept;
    logic             w_start;
    logic             w_restart;
    logic [CNT_W-1:0] w_len_in;
    logic [CNT_W-1:0] w_len_cur;
    logic             w_dir_cur;

    assign in_ready  = !clear && ((r_state == FILL) || out_ready);
    assign w_accept  = in_valid && in_ready;

    // In FULL the counter rests at 0, so an accepted beat there also starts a frame.
    assign w_start   = w_accept && ((r_state == FULL) || (r_cnt == {CNT_W{1'b0}}));
    assign w_restart = (r_state == FULL) && out_ready && !clear;

    assign w_len_in  = CNT_W'(eff_len(32'(len), 32'(DEPTH)));
    // The starting beat must already use the new dir/len, not the stale latch.
    assign w_len_cur = w_start ? w_len_in : r_len;
    assign w_dir_cur = w_start ? dir : r_dir;

    // Frame FSM, beat counter and per-frame dir/len latch.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= FILL;
            r_cnt   <= {CNT_W{1'b0}};
            r_dir   <= 1'b1;
            r_len   <= CNT_W'(DEPTH);
        end else if (clear) begin
            r_state <= FILL;
            r_cnt   <= {CNT_W{1'b0}};
        end else begin
            if (w_start) begin
                r_dir <= dir;
                r_len <= w_len_in;
            end
            case (r_state)
                FILL: begin
                    if (w_accept) begin
                        if (r_cnt == (w_len_cur - CNT_W'(1))) begin
                            r_state <= FULL;
                            r_cnt   <= {CNT_W{1'b0}};
                        end else begin
                            r_state <= FILL;
                            r_cnt   <= r_cnt + CNT_W'(1);
                        end
                    end
                end
                FULL: begin
                    if (out_ready) begin
                        if (in_valid) begin
                            // Single-beat frames complete on the restarting beat.
                            if (w_len_in == CNT_W'(1)) begin
                                r_state <= FULL;
                                r_cnt   <= {CNT_W{1'b0}};
                            end else begin
                                r_state <= FILL;
                                r_cnt   <= CNT_W'(1);
                            end
                        end else begin
                            r_state <= FILL;
                            r_cnt   <= {CNT_W{1'b0}};
                        end
                    end
                end
                default: begin
                    r_state <= FILL;
                    r_cnt   <= {CNT_W{1'b0}};
                end
            endcase
        end
    end

    assign out_valid = (r_state == FULL);

    genvar g;
    generate
        for (g = 0; g < LANES; g++) begin : g_lane
            logic [DEPTH-1:0] w_data;
            logic [CNT_W-1:0] w_ones;

            sipo_lane #(
                .DEPTH (DEPTH),
                .CNT_W (CNT_W)
            ) u_lane (
                .clk     (clk),
                .reset   (reset),
                .clear   (clear),
                .shift   (w_accept),
                .restart (w_restart),
                .dir     (w_dir_cur),
                .in      (in_data[g]),
                .data    (w_data),
                .ones    (w_ones)
            );

            assign out_data[g*DEPTH +: DEPTH] = w_data;
            assign out_ones[g*CNT_W +: CNT_W] = w_ones;
        end
    endgenerate

endmodule

// File: doc/sipo_frame_shift.md
# sipo_frame_shift

Multi-lane, handshaked serial-in/parallel-out frame collector for the unary shift MAC datapath. Each of `LANES` serial streams shifts into its own `DEPTH`-bit register, one bit per accepted beat. Shift direction and frame length are selectable at run time. A per-lane running ones-count converts unary streams to binary. A completed frame is presented on a valid/ready output and held until consumed; back-to-back frames stream with no bubble.

## Interface
- `LANES`, 4, number of parallel serial lanes
- `DEPTH`, 16, maximum frame length in bits per lane (≥2)
- `CNT_W`, `$clog2(DEPTH+1)`, width of length/count fields (derived, not overridden)

- `clk` input 1: single clock, all state on rising edge
- `reset` input 1: asynchronous, active-high; clears all state
- `clear` input 1: synchronous abort; discards partial or held frame
- `dir` input 1: 1 = right shift (new bit enters MSB), 0 = left shift (new bit enters LSB); sampled at frame start
- `len` input CNT_W: frame length in beats; sampled at frame start; 0 or >DEPTH means DEPTH
- `in_valid` input 1: beat available
- `in_ready` output 1: beat accepted when `in_valid & in_ready`
- `in_data` input LANES: one bit per lane for this beat
- `out_valid` output 1: completed frame held on outputs
- `out_ready` input 1: consumer takes frame when `out_valid & out_ready`
- `out_data` output LANES*DEPTH: lane i at bits [i*DEPTH +: DEPTH]
- `out_ones` output LANES*CNT_W: lane i ones-count at [i*CNT_W +: CNT_W]

## Operation
- States: FILL (collecting), FULL (frame held).
- FILL: `in_ready`=1. Each accepted beat shifts every lane per latched `dir`, adds `in_data[i]` to lane i's ones-count, increments the beat counter. On the beat where the counter reaches latched length−1, go to FULL.
- Frame start is the first accepted beat with counter=0. `dir` and `len` are latched then and are fixed for the frame. Mid-frame changes are ignored.
- FULL: `out_valid`=1, `in_ready`=`out_ready` (combinational).
  - `out_ready` & !`in_valid`: registers and counts zeroed, go to FILL.
  - `out_ready` & `in_valid`: the new beat starts the next frame. Registers load as if shifted from zero, count=`in_data`, counter=1, `dir`/`len` are re-latched, state goes to FILL. If the latched length is 1, state stays FULL.
  - !`out_ready`: hold everything; input stalls.
- Short frames (length L<DEPTH): right shift leaves data in the top L bits; left shift leaves it in the bottom L bits. Unused bits are 0.
- `clear` dominates all other inputs: state goes to FILL, counter, registers and counts go to 0, and a held frame is dropped. During `clear`, `in_ready`=0.
- `out_data`/`out_ones` are visible while filling but meaningful only when `out_valid`=1.
- Ones-count never overflows: at most DEPTH ones fit in CNT_W bits.

## Timing
- Reset values: `out_valid`=0, `in_ready`=1, `out_data`=0, `out_ones`=0, state FILL, counter 0, latched `dir`=1, latched `len`=DEPTH.
- `out_valid` rises the cycle after the L-th beat is accepted.
- Full-rate throughput: one frame per L cycles with no bubble while `out_ready`=1.
- `reset` assertion mid-frame zeroes outputs immediately (asynchronous). Deassertion resumes in FILL on the next edge.
- Outputs are registered, except `in_ready`, which is a function of state, `out_ready` and `clear`.

## Structure
- Package `sipo_frame_pkg`:
  - `typedef enum logic {FILL, FULL} sipo_state_t`
  - function `eff_len(len, DEPTH)` that clamps 0 or >DEPTH to DEPTH
- Sub-module `sipo_lane`: one DEPTH-bit shift register plus CNT_W ones-counter, with ports `shift`, `restart`, `dir`, `in`, `clear`. It is instantiated LANES times in a generate loop.
- Top level holds the FSM, beat counter and latched `dir`/`len`.

## Test plan
- LANES=4, DEPTH=8, `dir`=1, `len`=0, stream lane0 = 1,0,1,1,0,0,1,0, other lanes 0, `out_ready`=1 → after beat 8, `out_valid` pulses 1 cycle; lane0 `out_data`=8'b01001101, `out_ones`=4; lanes 1-3 = 0.
- Same stream with `dir`=0 → lane0 `out_data`=8'b10110010.
- `len`=3, `dir`=1, all lanes 1,1,1, `out_ready`=0 for 5 cycles → every lane reads 8'b11100000 with ones=3. `out_valid` holds and `in_ready`=0 throughout. The frame is released on the `out_ready` cycle.
- Continuous `in_valid`/`out_ready` with `len`=4 for 3 frames → `out_valid` every 4th cycle, no dropped or duplicated beats. Toggle `dir` mid-frame → direction changes only at the next frame.
- `clear` asserted after 5 of 8 beats, and separately while FULL → next frame is correct from zero, and the held frame is never seen as valid again.
- `reset` pulsed mid-frame and asynchronously between edges → all outputs are 0 immediately, and a full 8-beat frame afterwards is correct.
